testeio_error_sum_poller: RTL and testbench

Avalon-MM read master for the chromosome error-sum PIO slave. While running, it polls address 0 of the slave at a programmable interval and captures each returned 32-bit error sum. It counts the samples and presents the latest value, plus the minimum value when that feature is compiled in, to the GA control logic. It sits between the fitness evaluator and the error-sum PIO on the same clock domain.

---
 rtl/testeio_error_sum_poller.sv | 170 +++++++++++++++++
 tb/tb_testeio_error_sum_poller.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/testeio_error_sum_poller.sv
// Avalon-MM read master that polls the chromosome error-sum PIO and reports samples.
// Optional minimum tracking on best_data is compiled in with `define POLL_MIN_TRACK_EN.
module testeio_error_sum_poller #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 2,
  parameter int POLL_ADDR = 0,
  parameter int POLL_DIV  = 16,
  parameter int READ_LAT  = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              busy,
  output logic              sample_valid,
  output logic [DATA_W-1:0] sample_data,
  output logic [CNT_W-1:0]  sample_count,
  output logic [DATA_W-1:0] best_data
);

  localparam int GAP_W = $clog2(POLL_DIV + 2);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_LAT  = 3'd2,
    ST_CAP  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [2:0]         lat_cnt_r, lat_cnt_nxt_s;
  logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_nxt_s;
  logic               stop_pending_r, stop_pending_nxt_s;
  logic               capture_s;
  logic               launch_s;
  logic               avm_read_r;
  logic               busy_r;
  logic               sample_valid_r;
  logic [DATA_W-1:0]  sample_data_r;
  logic [CNT_W-1:0]   sample_count_r;

  assign avm_address  = ADDR_W'(POLL_ADDR);
  assign avm_read     = avm_read_r;
  assign busy         = busy_r;
  assign sample_valid = sample_valid_r;
  assign sample_data  = sample_data_r;
  assign sample_count = sample_count_r;

  // Next-state logic for the poll sequencer and its counters
  always_comb begin
    state_nxt_s        = state_r;
    lat_cnt_nxt_s      = lat_cnt_r;
    gap_cnt_nxt_s      = gap_cnt_r;
    stop_pending_nxt_s = stop_pending_r;
    capture_s          = 1'b0;
    launch_s           = 1'b0;
    case (state_r)
      ST_IDLE: begin
        stop_pending_nxt_s = 1'b0;
        if (start && !stop) begin
          state_nxt_s = ST_REQ;
          launch_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // read stays asserted until the slave accepts, even if stop arrives
        stop_pending_nxt_s = stop_pending_r | stop;
        if (!avm_waitrequest) begin
          state_nxt_s   = ST_LAT;
          lat_cnt_nxt_s = 3'(READ_LAT);
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_LAT: begin
        stop_pending_nxt_s = stop_pending_r | stop;
        if (lat_cnt_r <= 3'd1) begin
          state_nxt_s = ST_CAP;
          capture_s   = 1'b1;
        end else begin
          lat_cnt_nxt_s = lat_cnt_r - 3'd1;
        end
      end
      ST_CAP: begin
        if (stop_pending_r || stop) begin
          state_nxt_s        = ST_IDLE;
          stop_pending_nxt_s = 1'b0;
        end else if (POLL_DIV == 0) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s   = ST_GAP;
          gap_cnt_nxt_s = GAP_W'(POLL_DIV);
        end
      end
      ST_GAP: begin
        if (stop || stop_pending_r) begin
          state_nxt_s        = ST_IDLE;
          stop_pending_nxt_s = 1'b0;
        end else if (gap_cnt_r <= GAP_W'(1)) begin
          state_nxt_s = ST_REQ;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r - GAP_W'(1);
        end
      end
      default: begin
        state_nxt_s        = ST_IDLE;
        stop_pending_nxt_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      lat_cnt_r      <= 3'd0;
      gap_cnt_r      <= {GAP_W{1'b0}};
      stop_pending_r <= 1'b0;
      avm_read_r     <= 1'b0;
      busy_r         <= 1'b0;
      sample_valid_r <= 1'b0;
      sample_data_r  <= {DATA_W{1'b0}};
      sample_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r        <= state_nxt_s;
      lat_cnt_r      <= lat_cnt_nxt_s;
      gap_cnt_r      <= gap_cnt_nxt_s;
      stop_pending_r <= stop_pending_nxt_s;
      avm_read_r     <= (state_nxt_s == ST_REQ);
      busy_r         <= (state_nxt_s != ST_IDLE);
      sample_valid_r <= capture_s;
      if (capture_s) begin
        sample_data_r <= avm_readdata;
      end
      if (launch_s) begin
        sample_count_r <= {CNT_W{1'b0}};
      end else if (capture_s && !(&sample_count_r)) begin
        sample_count_r <= sample_count_r + CNT_W'(1);
      end
    end
  end

`ifdef POLL_MIN_TRACK_EN
  logic [DATA_W-1:0] best_r;

  // Running unsigned minimum, evaluated against the sample shown during CAP
  always_ff @(posedge clk) begin
    if (reset) begin
      best_r <= {DATA_W{1'b1}};
    end else if (launch_s) begin
      best_r <= {DATA_W{1'b1}};
    end else if (state_r == ST_CAP && sample_data_r < best_r) begin
      best_r <= sample_data_r;
    end
  end

  assign best_data = best_r;
`else
  assign best_data = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_testeio_error_sum_poller.sv
// Self-checking bench for testeio_error_sum_poller with scoreboarded slave responses.
module tb_testeio_error_sum_poller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: POLL_DIV=4, READ_LAT=1, CNT_W=16
  logic        rst_a = 1'b1, start_a = 1'b0, stop_a = 1'b0, wreq_a = 1'b0;
  logic [1:0]  addr_a;
  logic        read_a, busy_a, sv_a;
  logic [31:0] rd_a, sd_a, best_a;
  logic [15:0] cnt_a;

  // DUT B: POLL_DIV=0, READ_LAT=1, CNT_W=2
  logic        rst_b = 1'b1, start_b = 1'b0, stop_b = 1'b0, wreq_b = 1'b0;
  logic [1:0]  addr_b;
  logic        read_b, busy_b, sv_b;
  logic [31:0] rd_b, sd_b, best_b;
  logic [1:0]  cnt_b;

  testeio_error_sum_poller #(.DATA_W(32), .ADDR_W(2), .POLL_ADDR(0), .POLL_DIV(4),
                             .READ_LAT(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .stop(stop_a),
    .avm_address(addr_a), .avm_read(read_a), .avm_waitrequest(wreq_a),
    .avm_readdata(rd_a), .busy(busy_a), .sample_valid(sv_a),
    .sample_data(sd_a), .sample_count(cnt_a), .best_data(best_a));

  testeio_error_sum_poller #(.DATA_W(32), .ADDR_W(2), .POLL_ADDR(0), .POLL_DIV(0),
                             .READ_LAT(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .stop(stop_b),
    .avm_address(addr_b), .avm_read(read_b), .avm_waitrequest(wreq_b),
    .avm_readdata(rd_b), .busy(busy_b), .sample_valid(sv_b),
    .sample_data(sd_b), .sample_count(cnt_b), .best_data(best_b));

  int n_cmp = 0;
  int n_bad = 0;

`ifdef POLL_MIN_TRACK_EN
  localparam logic [31:0] BEST_RST = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] BEST_RST = 32'h0000_0000;
`endif

  // Slave models: data valid only in the cycle after accept, garbage otherwise
  logic [31:0] slave_val_a = 32'h0000_00A5;
  logic [31:0] rsp_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_qb[$];
  logic [31:0] nb = 32'h0000_0100;

  function automatic logic [31:0] take_a();
    logic [31:0] v;
    if (rsp_q.size() > 0) v = rsp_q.pop_front();
    else v = slave_val_a;
    exp_q.push_back(v);
    return v;
  endfunction

  function automatic logic [31:0] take_b();
    nb = nb + 32'd1;
    exp_qb.push_back(nb);
    return nb;
  endfunction

  always @(posedge clk) begin
    if (rst_a) rd_a <= 32'h0;
    else if (read_a === 1'b1 && wreq_a === 1'b0) rd_a <= take_a();
    else rd_a <= 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (rst_b) rd_b <= 32'h0;
    else if (read_b === 1'b1 && wreq_b === 1'b0) rd_b <= take_b();
    else rd_b <= 32'hDEAD_BEEF;
  end

  // Per-cycle history of DUT A, cycle 0 is the start cycle
  logic [63:0] rd_v, sv_v, busy_v;
  logic [31:0] sd_h[64];
  logic [31:0] bd_h[64];
  logic [15:0] cnt_h[64];
  int          addr_bad;

  task automatic run_a(input int ncyc, input int w_lo, input int w_hi, input int stop_at,
                       input int st1, input int st2);
    rd_v = '0; sv_v = '0; busy_v = '0; addr_bad = 0;
    for (int c = 0; c <= ncyc; c++) begin
      start_a = (c == 0) || (c == st1) || (c == st2);
      stop_a  = (c == stop_at);
      wreq_a  = (c >= w_lo) && (c <= w_hi);
      rd_v[c] = read_a; sv_v[c] = sv_a; busy_v[c] = busy_a;
      sd_h[c] = sd_a; bd_h[c] = best_a; cnt_h[c] = cnt_a;
      if (addr_a !== 2'd0) addr_bad++;
      @(posedge clk); #1;
    end
    start_a = 1'b0; stop_a = 1'b0; wreq_a = 1'b0;
  endtask

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({read_a, busy_a, sv_a} !== 3'b000) begin n_bad++; $display("FAIL reset_ctl got %b want 000", {read_a, busy_a, sv_a}); end
    n_cmp++; if (sd_a !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", sd_a); end
    n_cmp++; if (cnt_a !== 16'h0) begin n_bad++; $display("FAIL reset_count got %h want 0", cnt_a); end
    n_cmp++; if (best_a !== BEST_RST) begin n_bad++; $display("FAIL reset_best got %h want %h", best_a, BEST_RST); end
    n_cmp++; if (addr_a !== 2'd0) begin n_bad++; $display("FAIL reset_addr got %h want 0", addr_a); end
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [63:0] e_rd, e_sv, e_busy;
    logic [31:0] e;
    int ec;
    slave_val_a = 32'h0000_00A5;
    run_a(13, 1, 0, 11, -1, -1);
    e_rd = '0; e_rd[1] = 1'b1; e_rd[8] = 1'b1;
    e_sv = '0; e_sv[3] = 1'b1; e_sv[10] = 1'b1;
    e_busy = '0; for (int c = 1; c <= 11; c++) e_busy[c] = 1'b1;
    n_cmp++; if (rd_v !== e_rd) begin n_bad++; $display("FAIL basic_read got %h want %h", rd_v, e_rd); end
    n_cmp++; if (sv_v !== e_sv) begin n_bad++; $display("FAIL basic_valid got %h want %h", sv_v, e_sv); end
    n_cmp++; if (busy_v !== e_busy) begin n_bad++; $display("FAIL basic_busy got %h want %h", busy_v, e_busy); end
    n_cmp++; if (addr_bad != 0) begin n_bad++; $display("FAIL basic_addr got %0d bad cycles want 0", addr_bad); end
    ec = 0;
    for (int c = 0; c <= 13; c++) begin
      if (e_sv[c]) begin
        ec++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        n_cmp++; if (sd_h[c] !== e) begin n_bad++; $display("FAIL basic_data c=%0d got %h want %h", c, sd_h[c], e); end
        n_cmp++; if (cnt_h[c] !== 16'(ec)) begin n_bad++; $display("FAIL basic_count c=%0d got %0d want %0d", c, cnt_h[c], ec); end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL basic_sb_left got %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_waitrequest;
    logic [63:0] e_rd, e_sv, e_busy;
    logic [31:0] e;
    int ec;
    slave_val_a = 32'h0000_1234;
    run_a(17, 1, 3, 14, -1, -1);
    e_rd = '0; e_rd[1] = 1'b1; e_rd[2] = 1'b1; e_rd[3] = 1'b1; e_rd[4] = 1'b1; e_rd[11] = 1'b1;
    e_sv = '0; e_sv[6] = 1'b1; e_sv[13] = 1'b1;
    e_busy = '0; for (int c = 1; c <= 14; c++) e_busy[c] = 1'b1;
    n_cmp++; if (rd_v !== e_rd) begin n_bad++; $display("FAIL wait_read got %h want %h", rd_v, e_rd); end
    n_cmp++; if (sv_v !== e_sv) begin n_bad++; $display("FAIL wait_valid got %h want %h", sv_v, e_sv); end
    n_cmp++; if (busy_v !== e_busy) begin n_bad++; $display("FAIL wait_busy got %h want %h", busy_v, e_busy); end
    n_cmp++; if (addr_bad != 0) begin n_bad++; $display("FAIL wait_addr got %0d bad cycles want 0", addr_bad); end
    ec = 0;
    for (int c = 0; c <= 17; c++) begin
      if (e_sv[c]) begin
        ec++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        n_cmp++; if (sd_h[c] !== e) begin n_bad++; $display("FAIL wait_data c=%0d got %h want %h", c, sd_h[c], e); end
        n_cmp++; if (cnt_h[c] !== 16'(ec)) begin n_bad++; $display("FAIL wait_count c=%0d got %0d want %0d", c, cnt_h[c], ec); end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_stop;
    logic [63:0] e_rd, e_sv, e_busy;
    logic [31:0] e;
    slave_val_a = 32'h0BAD_F00D;
    run_a(12, 1, 0, 2, -1, -1);
    e_rd = '0; e_rd[1] = 1'b1;
    e_sv = '0; e_sv[3] = 1'b1;
    e_busy = '0; e_busy[1] = 1'b1; e_busy[2] = 1'b1; e_busy[3] = 1'b1;
    n_cmp++; if (rd_v !== e_rd) begin n_bad++; $display("FAIL stop_read got %h want %h", rd_v, e_rd); end
    n_cmp++; if (sv_v !== e_sv) begin n_bad++; $display("FAIL stop_valid got %h want %h", sv_v, e_sv); end
    n_cmp++; if (busy_v !== e_busy) begin n_bad++; $display("FAIL stop_busy got %h want %h", busy_v, e_busy); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    n_cmp++; if (sd_h[3] !== e) begin n_bad++; $display("FAIL stop_data got %h want %h", sd_h[3], e); end
    n_cmp++; if (cnt_h[12] !== 16'd1) begin n_bad++; $display("FAIL stop_count got %0d want 1", cnt_h[12]); end
    exp_q.delete();
  endtask

  task automatic test_start_stop;
    logic [63:0] e_rd, e_sv;
    run_a(8, 1, 0, 0, -1, -1);
    n_cmp++; if (busy_v !== 64'h0) begin n_bad++; $display("FAIL startstop_busy got %h want 0", busy_v); end
    n_cmp++; if (rd_v !== 64'h0) begin n_bad++; $display("FAIL startstop_read got %h want 0", rd_v); end
    slave_val_a = 32'h0000_0077;
    run_a(13, 1, 0, 11, 2, 5);
    e_rd = '0; e_rd[1] = 1'b1; e_rd[8] = 1'b1;
    e_sv = '0; e_sv[3] = 1'b1; e_sv[10] = 1'b1;
    n_cmp++; if (rd_v !== e_rd) begin n_bad++; $display("FAIL busystart_read got %h want %h", rd_v, e_rd); end
    n_cmp++; if (sv_v !== e_sv) begin n_bad++; $display("FAIL busystart_valid got %h want %h", sv_v, e_sv); end
    n_cmp++; if (cnt_h[6] !== 16'd1) begin n_bad++; $display("FAIL busystart_count1 got %0d want 1", cnt_h[6]); end
    n_cmp++; if (cnt_h[10] !== 16'd2) begin n_bad++; $display("FAIL busystart_count2 got %0d want 2", cnt_h[10]); end
    exp_q.delete();
  endtask

  task automatic test_min_track;
    logic [31:0] e_best[4];
    logic [31:0] e;
    int vc[4];
    vc = '{3, 10, 17, 24};
`ifdef POLL_MIN_TRACK_EN
    e_best = '{32'd300, 32'd120, 32'd120, 32'd120};
`else
    e_best = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
    rsp_q.push_back(32'd300); rsp_q.push_back(32'd120);
    rsp_q.push_back(32'd500); rsp_q.push_back(32'd120);
    run_a(27, 1, 0, 25, -1, -1);
    for (int i = 0; i < 4; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
      n_cmp++; if (sv_v[vc[i]] !== 1'b1 || sd_h[vc[i]] !== e) begin n_bad++; $display("FAIL min_data i=%0d got %b/%0d want 1/%0d", i, sv_v[vc[i]], sd_h[vc[i]], e); end
      n_cmp++; if (bd_h[vc[i] + 1] !== e_best[i]) begin n_bad++; $display("FAIL min_best i=%0d got %0d want %0d", i, bd_h[vc[i] + 1], e_best[i]); end
    end
    exp_q.delete();
    slave_val_a = 32'h0000_00A5;
    run_a(6, 1, 0, 2, -1, -1);
    for (int c = 1; c <= 3; c++) begin
      n_cmp++; if (bd_h[c] !== BEST_RST) begin n_bad++; $display("FAIL min_restart c=%0d got %h want %h", c, bd_h[c], BEST_RST); end
    end
`ifdef POLL_MIN_TRACK_EN
    e = 32'h0000_00A5;
`else
    e = 32'h0;
`endif
    n_cmp++; if (bd_h[4] !== e) begin n_bad++; $display("FAIL min_after_restart got %h want %h", bd_h[4], e); end
    exp_q.delete();
  endtask

  task automatic test_saturate_reset;
    logic [63:0] b_sv, b_rd, e_sv, e_rd;
    logic [1:0]  b_cnt[64];
    logic [31:0] b_sd[64];
    logic [31:0] e;
    int ec;
    b_sv = '0; b_rd = '0; e_sv = '0; e_rd = '0;
    for (int c = 0; c <= 19; c++) begin
      start_b = (c == 0);
      wreq_b  = (c == 19);
      rst_b   = (c == 19);
      b_sv[c] = sv_b; b_rd[c] = read_b; b_cnt[c] = cnt_b; b_sd[c] = sd_b;
      if (c >= 3 && c <= 18 && (c % 3) == 0) e_sv[c] = 1'b1;
      if (c >= 1 && (c % 3) == 1) e_rd[c] = 1'b1;
      @(posedge clk); #1;
    end
    start_b = 1'b0;
    n_cmp++; if (b_sv !== e_sv) begin n_bad++; $display("FAIL sat_valid got %h want %h", b_sv, e_sv); end
    n_cmp++; if (b_rd !== e_rd) begin n_bad++; $display("FAIL sat_read got %h want %h", b_rd, e_rd); end
    ec = 0;
    for (int c = 0; c <= 19; c++) begin
      if (e_sv[c]) begin
        if (ec < 3) ec++;
        e = (exp_qb.size() > 0) ? exp_qb.pop_front() : 32'hXXXX_XXXX;
        n_cmp++; if (b_cnt[c] !== 2'(ec)) begin n_bad++; $display("FAIL sat_count c=%0d got %0d want %0d", c, b_cnt[c], ec); end
        n_cmp++; if (b_sd[c] !== e) begin n_bad++; $display("FAIL sat_data c=%0d got %h want %h", c, b_sd[c], e); end
      end
    end
    n_cmp++; if ({read_b, busy_b, sv_b} !== 3'b000) begin n_bad++; $display("FAIL rst_mid_ctl got %b want 000", {read_b, busy_b, sv_b}); end
    n_cmp++; if (sd_b !== 32'h0 || cnt_b !== 2'd0) begin n_bad++; $display("FAIL rst_mid_data got %h/%0d want 0/0", sd_b, cnt_b); end
    n_cmp++; if (best_b !== BEST_RST) begin n_bad++; $display("FAIL rst_mid_best got %h want %h", best_b, BEST_RST); end
    n_cmp++; if (exp_qb.size() != 0) begin n_bad++; $display("FAIL rst_mid_sb_left got %0d want 0", exp_qb.size()); end
    rst_b = 1'b0; wreq_b = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_waitrequest();
    test_stop();
    test_start_stop();
    test_min_track();
    test_saturate_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
